mod_reduce: RTL and testbench



---
 rtl/rsa_pkg.sv | 21 ++
 rtl/mod_sub_step.sv | 32 +++
 rtl/mod_reduce.sv | 123 ++++++++++++
 tb/tb_mod_reduce.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath blocks.
//   RSA_WIDTH : default operand/modulus width
//   state_t   : reduction FSM states
//   cnt_init  : first value of the bit counter for a given operand width
package rsa_pkg;

  localparam int RSA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The product has 2*w bits and one is consumed per RUN cycle, so the
  // counter runs from 2*w-1 down to 0.
  function automatic int cnt_init(input int w);
    return 2 * w - 1;
  endfunction

endpackage

// File: rtl/mod_sub_step.sv
// One restoring shift-subtract step of a modular reduction.
// Shifts the next product bit into the partial remainder and subtracts the
// modulus when the shifted value is not below it.
//   rem_in  [WIDTH-1:0] : current partial remainder (always < n)
//   bit_in              : next product bit, MSB first
//   n       [WIDTH-1:0] : modulus
//   rem_out [WIDTH-1:0] : updated partial remainder (always < n when n != 0)
module mod_sub_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] rem_out
);

  logic [WIDTH:0] t;
  logic           ge;

  // t < 2*n, so a single conditional subtract brings it back below n and
  // the result always fits in WIDTH bits.
  assign t  = {rem_in, bit_in};
  assign ge = (t >= {1'b0, n});

  always_comb begin
    rem_out = t[WIDTH-1:0];
    if (ge) begin
      rem_out = WIDTH'(t - {1'b0, n});
    end
  end

endmodule

// File: rtl/mod_reduce.sv
// Sequential modular reduction R = P mod N, one product bit per clock.
// Sits behind the shift-add multiplier; its result is the next operand of
// the modular-exponentiation sequencer.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, aborts any reduction silently
//   start : request pulse, only looked at in IDLE
//   p     : 2*WIDTH-bit product, captured on an accepted start
//   n     : WIDTH-bit modulus, captured on an accepted start
//   busy  : high while the reduction iterates
//   done  : one-cycle pulse, r and err are valid in that cycle
//   r     : remainder, held from done until the next accepted start
//   err   : set with done when the modulus was zero, held with r
//
// Handshake: a request is accepted on a clock edge where start=1 and the
// block is idle; exactly one done pulse follows each accepted request
// unless rst intervenes. start seen while busy or finishing is dropped.
module mod_reduce
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH,
  parameter int CNTW  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] p,
  input  logic [WIDTH-1:0]   n,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   r,
  output logic               err
);

  state_t             state, state_next;
  logic [2*WIDTH-1:0] ps;
  logic [WIDTH-1:0]   nr;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   rem_next;
  logic [CNTW-1:0]    count;
  logic               done_q;
  logic [WIDTH-1:0]   r_q;
  logic               err_q;

  // The remainder register only needs WIDTH bits: every update leaves it
  // below the modulus, so the extra top bit of the shifted value lives
  // only inside the step logic.
  mod_sub_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem),
    .bit_in  (ps[2*WIDTH-1]),
    .n       (nr),
    .rem_out (rem_next)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (n == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (count == '0) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ps     <= '0;
      nr     <= '0;
      rem    <= '0;
      count  <= '0;
      done_q <= 1'b0;
      r_q    <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_next;
      // done is registered from the DONE state, so it lands one cycle
      // after the final iteration and r is already stable under it.
      done_q <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            ps    <= p;
            nr    <= n;
            rem   <= '0;
            count <= CNTW'(cnt_init(WIDTH));
            if (n == '0) begin
              r_q   <= '0;
              err_q <= 1'b1;
            end else begin
              err_q <= 1'b0;
            end
          end
        end
        RUN: begin
          ps  <= ps << 1;
          rem <= rem_next;
          if (count == '0) begin
            r_q <= rem_next;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = done_q;
  assign r    = r_q;
  assign err  = err_q;

endmodule

// File: tb/tb_mod_reduce.sv
// Testbench for mod_reduce: directed and random reductions, expected
// results queued at request time and compared whenever done pulses.
module tb_mod_reduce;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [2*W-1:0] p;
  logic [W-1:0]   n;
  logic           busy;
  logic           done;
  logic [W-1:0]   r;
  logic           err;

  logic [W:0] exp_q[$];   // {err, r}
  int checks = 0;
  int errors = 0;

  mod_reduce #(.WIDTH(W), .CNTW(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .p     (p),
    .n     (n),
    .busy  (busy),
    .done  (done),
    .r     (r),
    .err   (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W:0] model(input int pv, input int nv);
    if (nv == 0) return {1'b1, {W{1'b0}}};
    return {1'b0, W'(pv % nv)};
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_op(input int pv, input int nv);
    @(negedge clk);
    p     = (2*W)'(pv);
    n     = W'(nv);
    start = 1'b1;
    exp_q.push_back(model(pv, nv));
  endtask

  // Counts edges from the start edge (edge 1) until done is seen, checking
  // latency and busy duration. With scramble set, p/n change every cycle
  // and a stray start is pulsed at cycle 5.
  task automatic wait_done(input int exp_lat, input int exp_busy, input bit scramble);
    int cyc = 0;
    int busy_cnt = 0;
    bit seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = scramble && (cyc == 5);
      if (scramble) begin
        p = (2*W)'($urandom);
        n = W'($urandom);
      end
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("done_seen", int'(seen), 1);
    check("latency", cyc, exp_lat);
    check("busy_cycles", busy_cnt, exp_busy);
  endtask

  task automatic idle_watch(input int cycles);
    int extra = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("no_done_when_idle", extra, 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("r", int'(r), int'(e[W-1:0]));
        check("err", int'(err), int'(e[W]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int pv;
    int nv;
    rst   = 1'b1;
    start = 1'b0;
    p     = '0;
    n     = '0;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_r", int'(r), 0);
    check("rst_err", int'(err), 0);
    idle_watch(40);

    // Basic
    start_op(40000, 221);
    wait_done(18, 16, 1'b0);

    // Boundaries
    start_op(65535, 255); wait_done(18, 16, 1'b0);
    start_op(65535, 1);   wait_done(18, 16, 1'b0);
    start_op(0, 7);       wait_done(18, 16, 1'b0);
    start_op(10000, 143); wait_done(18, 16, 1'b0);
    start_op(5, 200);     wait_done(18, 16, 1'b0);

    // Divide by zero, then recovery
    start_op(1234, 0);    wait_done(2, 0, 1'b0);
    start_op(100, 7);     wait_done(18, 16, 1'b0);

    // Ignored start and input scrambling during RUN
    start_op(40000, 221);
    wait_done(18, 16, 1'b1);
    begin
      int bad = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (r != W'(220) || done) bad++;
      end
      check("r_hold", bad, 0);
    end

    // Reset mid-operation
    start_op(40000, 221);
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_r", int'(r), 0);
    idle_watch(25);
    start_op(10000, 143);
    wait_done(18, 16, 1'b0);

    // Random operations
    for (int k = 0; k < 40; k++) begin
      pv = int'($urandom_range(0, 65535));
      nv = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
      start_op(pv, nv);
      if (nv == 0) wait_done(2, 0, 1'b0);
      else         wait_done(18, 16, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Start held high: operations accepted back to back
    start_op(40000, 221);
    exp_q.push_back(model(40000, 221));
    begin
      int dones = 0;
      for (int i = 0; i < 60 && dones < 2; i++) begin
        @(negedge clk);
        if (done) dones++;
        if (dones == 2) start = 1'b0;
      end
      start = 1'b0;
      check("held_start_ops", dones, 2);
    end
    idle_watch(25);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
